// File: rtl/animate_palette_fade_if.sv
// Pixel/score bundle between the colour mux, the palette animator and the VGA pins.
// The master drives the source pixel and game context; the slave returns the
// transformed pixel together with the fade status.
interface animate_palette_fade_if #(
    parameter int CW      = 4,
    parameter int SCORE_W = 14
);
    logic               valid;
    logic               pause;
    logic               mode;
    logic [SCORE_W-1:0] game_score;
    logic [CW-1:0]      old_r;
    logic [CW-1:0]      old_g;
    logic [CW-1:0]      old_b;
    logic [CW-1:0]      new_r;
    logic [CW-1:0]      new_g;
    logic [CW-1:0]      new_b;
    logic [CW-1:0]      level;
    logic               dark;

    modport master (
        output valid, pause, mode, game_score, old_r, old_g, old_b,
        input  new_r, new_g, new_b, level, dark
    );

    modport slave (
        input  valid, pause, mode, game_score, old_r, old_g, old_b,
        output new_r, new_g, new_b, level, dark
    );
endinterface

// File: rtl/animate_palette_fade.sv
// Day/night palette animator. A score-driven fade FSM (LIGHT -> TO_DARK -> DARK
// -> TO_LIGHT) walks a fade level between 0 and 2^CW-1, one step every
// STEP_CYCLES clocks, and every pixel channel is transformed against the current
// level with one clock of latency.
module animate_palette_fade #(
    parameter int CW          = 4,
    parameter int SCORE_W     = 14,
    parameter int PERIOD      = 700,
    parameter int DARK_LEN    = 150,
    parameter int STEP_CYCLES = 8388608
) (
    input  logic                  clk,
    input  logic                  rst_n,
    animate_palette_fade_if.slave bus
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [CW-1:0]      LMAX      = '1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [SCORE_W-1:0] PERIOD_S  = SCORE_W'(PERIOD);
    localparam logic [SCORE_W-1:0] DARKLEN_S = SCORE_W'(DARK_LEN);

    typedef enum logic [1:0] {
        S_LIGHT    = 2'd0,
        S_TO_DARK  = 2'd1,
        S_DARK     = 2'd2,
        S_TO_LIGHT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] trig_score_q, trig_score_d;
    logic [CW-1:0]      new_r_q, new_g_q, new_b_q;
    logic               dark_q;

    logic               score_zero;
    logic               trig;
    logic               ret;
    logic               counting;
    logic               tick;
    logic [SCORE_W-1:0] since_trig;

    // Per-channel transform: mode 0 is the distance |c - level|, mode 1 dims
    // towards black and clamps at zero.
    function automatic logic [CW-1:0] fade_channel(
        input logic [CW-1:0] c,
        input logic [CW-1:0] lvl,
        input logic          dim
    );
        logic [CW-1:0] res;
        if (dim) begin
            res = (c > lvl) ? (c - lvl) : '0;
        end else begin
            res = (c >= lvl) ? (c - lvl) : (lvl - c);
        end
        return res;
    endfunction

    // Score events and the step tick. The score distance wraps modulo 2^SCORE_W
    // on purpose so a score counter rolling over still ends the dark phase.
    always_comb begin
        score_zero = (bus.game_score == '0);
        since_trig = bus.game_score - trig_score_q;
        trig       = !score_zero
                     && ((bus.game_score % PERIOD_S) == '0)
                     && (bus.game_score != trig_score_q);
        ret        = (since_trig >= DARKLEN_S);
        counting   = ((state_q == S_TO_DARK) || (state_q == S_TO_LIGHT)) && !bus.pause;
        tick       = counting && (cnt_q == CNT_LAST);
    end

    // Next-state logic: restart clear beats everything, then the per-state
    // priority trig > ret > tick. trig only changes state from LIGHT/TO_LIGHT,
    // ret only from TO_DARK/DARK, so the two never compete within one state.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        trig_score_d = trig ? bus.game_score : trig_score_q;
        cnt_d        = cnt_q;
        if (counting) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            S_LIGHT: begin
                if (trig) state_d = S_TO_DARK;
            end
            S_TO_DARK: begin
                if (ret) begin
                    state_d = S_TO_LIGHT;
                end else if (tick) begin
                    level_d = (level_q == LMAX) ? LMAX : level_q + CW'(1);
                    if (level_d == LMAX) state_d = S_DARK;
                end
            end
            S_DARK: begin
                if (ret) state_d = S_TO_LIGHT;
            end
            S_TO_LIGHT: begin
                if (trig) begin
                    state_d = S_TO_DARK;
                end else if (tick) begin
                    level_d = (level_q == '0) ? '0 : level_q - CW'(1);
                    if (level_d == '0) state_d = S_LIGHT;
                end
            end
            default: state_d = S_LIGHT;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        if (score_zero) begin
            state_d      = S_LIGHT;
            level_d      = '0;
            trig_score_d = '0;
            cnt_d        = '0;
        end
    end

    // Fade control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LIGHT;
            level_q      <= '0;
            cnt_q        <= '0;
            trig_score_q <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            trig_score_q <= trig_score_d;
        end
    end

    // Registered pixel output using the level in force alongside the input
    // pixel; dark follows the state being entered so it lines up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_r_q <= '0;
            new_g_q <= '0;
            new_b_q <= '0;
            dark_q  <= 1'b0;
        end else begin
            new_r_q <= bus.valid ? fade_channel(bus.old_r, level_q, bus.mode) : '0;
            new_g_q <= bus.valid ? fade_channel(bus.old_g, level_q, bus.mode) : '0;
            new_b_q <= bus.valid ? fade_channel(bus.old_b, level_q, bus.mode) : '0;
            dark_q  <= (state_d == S_DARK);
        end
    end

    assign bus.new_r = new_r_q;
    assign bus.new_g = new_g_q;
    assign bus.new_b = new_b_q;
    assign bus.level = level_q;
    assign bus.dark  = dark_q;

endmodule

// File: tb/tb_animate_palette_fade.sv
// Bench for animate_palette_fade: directed fade scenarios plus a randomized
// tail, compared every cycle against a behavioural model of the fade rules.
module tb_animate_palette_fade;

    localparam int CW       = 4;
    localparam int SCORE_W  = 14;
    localparam int PERIOD   = 700;
    localparam int DARK_LEN = 150;
    localparam int STEP     = 4;
    localparam int LMAX     = 15;

    localparam int PH_LIGHT    = 0;
    localparam int PH_TO_DARK  = 1;
    localparam int PH_DARK     = 2;
    localparam int PH_TO_LIGHT = 3;

    logic clk;
    logic rst_n;

    animate_palette_fade_if #(.CW(CW), .SCORE_W(SCORE_W)) bus ();

    animate_palette_fade #(
        .CW(CW), .SCORE_W(SCORE_W), .PERIOD(PERIOD),
        .DARK_LEN(DARK_LEN), .STEP_CYCLES(STEP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model state
    int m_phase, m_level, m_trig, m_cnt;
    int e_r, e_g, e_b, e_dark;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_pix(input int c, input int l, input int dim, input int vld);
        int d;
        if (vld == 0) return 0;
        d = c - l;
        if (dim != 0) return (d > 0) ? d : 0;
        return (d < 0) ? -d : d;
    endfunction

    task automatic model_reset();
        m_phase = PH_LIGHT; m_level = 0; m_trig = 0; m_cnt = 0;
        e_r = 0; e_g = 0; e_b = 0; e_dark = 0;
    endtask

    // One clock of the fade rules, evaluated on the inputs seen at the edge.
    task automatic model_edge();
        int s, nph, moving;
        bit t, r, tk;
        s = int'(bus.game_score);
        e_r = ref_pix(int'(bus.old_r), m_level, int'(bus.mode), int'(bus.valid));
        e_g = ref_pix(int'(bus.old_g), m_level, int'(bus.mode), int'(bus.valid));
        e_b = ref_pix(int'(bus.old_b), m_level, int'(bus.mode), int'(bus.valid));
        if (s == 0) begin
            m_phase = PH_LIGHT; m_level = 0; m_trig = 0; m_cnt = 0;
        end else begin
            t  = (s % PERIOD == 0) && (s != m_trig);
            r  = (((s - m_trig) + (1 << SCORE_W)) % (1 << SCORE_W)) >= DARK_LEN;
            moving = ((m_phase == PH_TO_DARK) || (m_phase == PH_TO_LIGHT)) && !bus.pause;
            tk = moving && (m_cnt == STEP - 1);
            nph = m_phase;
            if (m_phase == PH_LIGHT && t) nph = PH_TO_DARK;
            else if (m_phase == PH_DARK && r) nph = PH_TO_LIGHT;
            else if (m_phase == PH_TO_DARK) begin
                if (r) nph = PH_TO_LIGHT;
                else if (tk) begin
                    m_level = (m_level + 1 > LMAX) ? LMAX : m_level + 1;
                    if (m_level == LMAX) nph = PH_DARK;
                end
            end else if (m_phase == PH_TO_LIGHT) begin
                if (t) nph = PH_TO_DARK;
                else if (tk) begin
                    m_level = (m_level - 1 < 0) ? 0 : m_level - 1;
                    if (m_level == 0) nph = PH_LIGHT;
                end
            end
            if (moving) m_cnt = (m_cnt + 1) % STEP;
            if (nph != m_phase) m_cnt = 0;
            m_phase = nph;
            if (t) m_trig = s;
        end
        e_dark = (m_phase == PH_DARK) ? 1 : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("new_r", 32'(bus.new_r), 32'(e_r));
        chk("new_g", 32'(bus.new_g), 32'(e_g));
        chk("new_b", 32'(bus.new_b), 32'(e_b));
        chk("level", 32'(bus.level), 32'(m_level));
        chk("dark",  32'(bus.dark),  32'(e_dark));
    endtask

    task automatic rand_pix();
        bus.old_r = CW'($urandom);
        bus.old_g = CW'($urandom);
        bus.old_b = CW'($urandom);
        bus.mode  = 1'($urandom);
        bus.valid = ($urandom_range(0, 7) != 0);
    endtask

    task automatic steps_rand(input int n);
        for (int i = 0; i < n; i++) begin
            rand_pix();
            step();
        end
    endtask

    task automatic set_pix(input int r, input int g, input int b, input int md, input int vld);
        bus.old_r = CW'(r); bus.old_g = CW'(g); bus.old_b = CW'(b);
        bus.mode = 1'(md); bus.valid = 1'(vld);
    endtask

    int sc_tab[8] = '{0, 700, 849, 850, 1400, 1549, 1550, 2100};

    initial begin
        // 1: reset and pass-through at level 0
        rst_n = 1'b0;
        bus.pause = 1'b0;
        bus.game_score = '0;
        set_pix(9, 3, 15, 0, 1);
        model_reset();
        #12;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_new_r", 32'(bus.new_r), 32'd0);
        chk("rst_dark",  32'(bus.dark),  32'd0);
        rst_n = 1'b1;
        step();
        chk("pass_r", 32'(bus.new_r), 32'd9);
        chk("pass_g", 32'(bus.new_g), 32'd3);
        chk("pass_b", 32'(bus.new_b), 32'd15);

        bus.game_score = 14'd700;
        steps_rand(21);
        chk("midfade_level", 32'(bus.level), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_level", 32'(bus.level), 32'd0);
        chk("async_new_g", 32'(bus.new_g), 32'd0);
        chk("async_dark",  32'(bus.dark),  32'd0);
        rst_n = 1'b1;
        bus.game_score = '0;
        steps_rand(2);

        // 2: fade to dark
        bus.game_score = 14'd700;
        steps_rand(1);
        steps_rand(59);
        chk("almost_dark", 32'(bus.dark), 32'd0);
        steps_rand(1);
        chk("dark_level", 32'(bus.level), 32'd15);
        chk("dark_flag",  32'(bus.dark),  32'd1);
        steps_rand(10);
        chk("held700_dark", 32'(bus.dark), 32'd1);

        // 3/4: stay dark, colour checks at full level, fade back to light
        bus.game_score = 14'd849;
        steps_rand(5);
        chk("849_dark", 32'(bus.dark), 32'd1);
        set_pix(9, 3, 15, 0, 1);
        step();
        chk("inv15_r", 32'(bus.new_r), 32'd6);
        chk("inv15_g", 32'(bus.new_g), 32'd12);
        chk("inv15_b", 32'(bus.new_b), 32'd0);
        set_pix(9, 3, 15, 1, 1);
        step();
        chk("dim15_r", 32'(bus.new_r), 32'd0);
        chk("dim15_b", 32'(bus.new_b), 32'd0);
        bus.game_score = 14'd850;
        steps_rand(1);
        chk("ret_dark",  32'(bus.dark),  32'd0);
        chk("ret_level", 32'(bus.level), 32'd15);
        steps_rand(40);
        chk("fall_level5", 32'(bus.level), 32'd5);
        set_pix(9, 3, 15, 1, 1);
        step();
        chk("dim5_r", 32'(bus.new_r), 32'd4);
        chk("dim5_g", 32'(bus.new_g), 32'd0);
        chk("dim5_b", 32'(bus.new_b), 32'd10);
        set_pix(9, 3, 15, 0, 0);
        step();
        chk("invalid_r", 32'(bus.new_r), 32'd0);
        chk("invalid_b", 32'(bus.new_b), 32'd0);
        steps_rand(18);
        chk("light_level", 32'(bus.level), 32'd0);
        chk("light_dark",  32'(bus.dark),  32'd0);

        // 5: ret mid-rise, reversal, pause
        bus.game_score = '0;
        steps_rand(1);
        bus.game_score = 14'd700;
        steps_rand(29);
        chk("rise_level7", 32'(bus.level), 32'd7);
        bus.game_score = 14'd850;
        steps_rand(1);
        chk("ret_keep7", 32'(bus.level), 32'd7);
        steps_rand(8);
        chk("fall_to5", 32'(bus.level), 32'd5);
        bus.game_score = 14'd1400;
        steps_rand(9);
        chk("rev_to7", 32'(bus.level), 32'd7);
        bus.pause = 1'b1;
        steps_rand(20);
        chk("pause_hold", 32'(bus.level), 32'd7);
        bus.pause = 1'b0;

        // 6: restart clear out of DARK, then retrigger on 700
        steps_rand(32);
        chk("dark_again", 32'(bus.dark), 32'd1);
        bus.game_score = '0;
        steps_rand(1);
        chk("clear_level", 32'(bus.level), 32'd0);
        chk("clear_dark",  32'(bus.dark),  32'd0);
        bus.game_score = 14'd700;
        steps_rand(5);
        chk("retrig_level", 32'(bus.level), 32'd1);

        // randomized tail
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)
                bus.game_score = 14'(sc_tab[$urandom_range(0, 7)]);
            else if ($urandom_range(0, 19) == 0)
                bus.game_score = bus.game_score + 14'd1;
            bus.pause = ($urandom_range(0, 5) == 0);
            steps_rand(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
